// File: rtl/rot_pkg.sv
// Shared types for the iterative left rotator: word width, amount type and FSM states.
package rot_pkg;

  localparam int unsigned ROT_W = 32;

  typedef logic [$clog2(ROT_W)-1:0] rot_amt_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } rot_state_e;

endpackage

// File: rtl/rotl_step.sv
// Combinational left rotate of a WIDTH-bit word by k (0..STEP) positions,
// built as one mux stage per bit of k, each stage rotating by a power of two.
module rotl_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  parameter int unsigned K_W   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] rot_c
);

  logic [WIDTH-1:0] stage [K_W+1];

  assign stage[0] = data;

  for (genvar i = 0; i < K_W; i++) begin : g_stage
    // Rotating by a multiple of WIDTH is the identity, so such a stage is a plain pass.
    localparam int unsigned SH = (32'd1 << i) % WIDTH;
    logic [WIDTH-1:0] rot;
    if (SH == 0) begin : g_pass
      assign rot = stage[i];
    end else begin : g_rot
      assign rot = {stage[i][WIDTH-1-SH:0], stage[i][WIDTH-1:WIDTH-SH]};
    end
    assign stage[i+1] = k[i] ? rot : stage[i];
  end

  assign rot_c = stage[K_W];

endmodule

// File: rtl/rotleft_seq.sv
// Multi-cycle variable-amount left rotator: accepts a word and amount, rotates by
// at most STEP positions per clock, then holds the result until it is taken.
module rotleft_seq
  import rot_pkg::*;
#(
  parameter int unsigned WIDTH = ROT_W,
  parameter int unsigned STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     busy
);

  localparam int unsigned AMT_W = $clog2(WIDTH);
  localparam int unsigned K_W   = $clog2(STEP + 1);

  rot_state_e       state, state_n;
  logic [WIDTH-1:0] data_r, data_n, rot_c;
  logic [AMT_W-1:0] rem_r, rem_n;
  logic [K_W-1:0]   step_amt;

  // Positions rotated this cycle: whatever remains, capped at STEP.
  always_comb begin
    if (32'(rem_r) < STEP) step_amt = K_W'(rem_r);
    else                   step_amt = K_W'(STEP);
  end

  rotl_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .K_W   (K_W)
  ) u_rotl_step (
    .data  (data_r),
    .k     (step_amt),
    .rot_c (rot_c)
  );

  always_comb begin
    state_n = state;
    data_n  = data_r;
    rem_n   = rem_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_n  = in_data;
          rem_n   = in_amt;
          state_n = (in_amt == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        data_n = rot_c;
        rem_n  = rem_r - AMT_W'(step_amt);
        if (rem_n == '0) state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode, so they
  // always match the state register and have no path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_r    <= '0;
      rem_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      data_r    <= data_n;
      rem_r     <= rem_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      busy      <= (state_n != IDLE);
    end
  end

  assign out_data = data_r;

endmodule
